// File: rtl/agc_gain_controller_pkg.sv
// Shared definitions for the AGC gain controller.
//   GAIN_W      : width of the gain index driven to mapping_function
//   COARSE_STEP : gain step applied for clipping / very weak signal
//   FINE_STEP   : gain step applied for slightly out-of-window peaks
//   agc_state_t : controller FSM states
package agc_gain_controller_pkg;

  localparam int unsigned GAIN_W      = 6;
  localparam int unsigned COARSE_STEP = 4;
  localparam int unsigned FINE_STEP   = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_DECIDE,
    ST_SETTLE,
    ST_LOCKED
  } agc_state_t;

endpackage

// File: rtl/agc_gain_controller_peak.sv
// agc_peak_detector: saturating |sample| and windowed peak (running max).
//   clk, resetn : clock, async active-low reset
//   measure_en  : high while a window is being accumulated; low clears
//                 the peak and the sample count
//   adc_data    : signed sample
//   adc_valid   : sample qualifier
//   peak        : running maximum magnitude of the current window
//   win_done    : high in the cycle the WIN_LEN-th valid sample is absorbed
module agc_peak_detector #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned WIN_LEN = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              measure_en,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [DATA_W-2:0] peak,
  output logic              win_done
);

  localparam int unsigned MW    = DATA_W - 1;
  localparam int unsigned CNT_W = $clog2(WIN_LEN);

  logic [MW-1:0]    mag;
  logic [CNT_W-1:0] cnt_q;
  logic             sample;

  // The most negative code has no positive counterpart; map it to full scale.
  always_comb begin
    mag = adc_data[MW-1:0];
    if (adc_data == {1'b1, {MW{1'b0}}})
      mag = '1;
    else if (adc_data[DATA_W-1])
      mag = MW'(-adc_data);
  end

  assign sample   = measure_en & adc_valid;
  assign win_done = sample && (cnt_q == CNT_W'(WIN_LEN - 1));

  // Count wraps to zero after the last sample since WIN_LEN is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      peak  <= '0;
      cnt_q <= '0;
    end else if (!measure_en) begin
      peak  <= '0;
      cnt_q <= '0;
    end else if (sample) begin
      if (mag > peak)
        peak <= mag;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/agc_gain_controller.sv
// agc_gain_controller: closed-loop AGC stepping a gain index until the
// windowed peak magnitude sits inside [thresh_low, thresh_high].
//   clk, resetn        : clock, async active-low reset
//   agc_en             : loop enable; low returns to IDLE and holds gain
//   adc_data/adc_valid : signed sample and qualifier
//   thresh_high/low    : peak-magnitude window
//   gain_array         : registered gain index 0..GAIN_MAX
//   gain_update        : one-cycle pulse when gain_array changes
//   agc_locked         : registered lock flag
module agc_gain_controller
  import agc_gain_controller_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned WIN_LEN    = 64,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned GAIN_MAX   = 38
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              agc_en,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [DATA_W-2:0] thresh_high,
  input  logic [DATA_W-2:0] thresh_low,
  output logic [GAIN_W-1:0] gain_array,
  output logic              gain_update,
  output logic              agc_locked
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam int unsigned IR_W  = $clog2(LOCK_CNT + 1);

  agc_state_t        state_q, state_d;
  logic [GAIN_W-1:0] gain_d;
  logic              upd_d, locked_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              eval_q, eval_d;
  logic              measure_en;
  logic [DATA_W-2:0] peak;
  logic              win_done;
  logic [6:0]        g7, g7_next;
  logic [GAIN_W-1:0] gain_calc;
  logic              in_range, changed;

  agc_peak_detector #(
    .DATA_W  (DATA_W),
    .WIN_LEN (WIN_LEN)
  ) u_peak (
    .clk        (clk),
    .resetn     (resetn),
    .measure_en (measure_en),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .peak       (peak),
    .win_done   (win_done)
  );

  // Gain decision on the completed window's peak, clamped in 7 bits.
  assign g7 = {1'b0, gain_array};

  always_comb begin
    in_range = 1'b0;
    g7_next  = g7;
    if (peak == '1)
      g7_next = (g7 < 7'(COARSE_STEP)) ? '0 : g7 - 7'(COARSE_STEP);
    else if (peak > thresh_high)
      g7_next = (g7 < 7'(FINE_STEP)) ? '0 : g7 - 7'(FINE_STEP);
    else if (peak < (thresh_low >> 2))
      g7_next = (g7 + 7'(COARSE_STEP) > 7'(GAIN_MAX)) ? 7'(GAIN_MAX) : g7 + 7'(COARSE_STEP);
    else if (peak < thresh_low)
      g7_next = (g7 + 7'(FINE_STEP) > 7'(GAIN_MAX)) ? 7'(GAIN_MAX) : g7 + 7'(FINE_STEP);
    else
      in_range = 1'b1;
  end

  assign gain_calc = GAIN_W'(g7_next);
  assign changed   = (gain_calc != gain_array);

  // LOCKED evaluates a finished window in a following cycle (eval_q) so the
  // decision sees the final registered peak, matching DECIDE timing.
  always_comb begin
    state_d    = state_q;
    gain_d     = gain_array;
    upd_d      = 1'b0;
    locked_d   = agc_locked;
    settle_d   = '0;
    ir_d       = ir_q;
    eval_d     = 1'b0;
    measure_en = 1'b0;
    if (!agc_en) begin
      state_d  = ST_IDLE;
      ir_d     = '0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_MEASURE;
        ST_MEASURE: begin
          measure_en = 1'b1;
          if (win_done)
            state_d = ST_DECIDE;
        end
        ST_DECIDE: begin
          if (in_range) begin
            if (ir_q + IR_W'(1) >= IR_W'(LOCK_CNT)) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
              ir_d     = '0;
            end else begin
              ir_d    = ir_q + IR_W'(1);
              state_d = ST_MEASURE;
            end
          end else begin
            ir_d = '0;
            if (changed) begin
              gain_d  = gain_calc;
              upd_d   = 1'b1;
              state_d = ST_SETTLE;
            end else begin
              state_d = ST_MEASURE;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_q == SET_W'(SETTLE_CYC - 1))
            state_d = ST_MEASURE;
          else
            settle_d = settle_q + SET_W'(1);
        end
        ST_LOCKED: begin
          if (eval_q) begin
            if (!in_range) begin
              locked_d = 1'b0;
              ir_d     = '0;
              if (changed) begin
                gain_d  = gain_calc;
                upd_d   = 1'b1;
                state_d = ST_SETTLE;
              end else begin
                state_d = ST_MEASURE;
              end
            end
          end else begin
            measure_en = 1'b1;
            if (win_done)
              eval_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      gain_array  <= GAIN_W'(GAIN_MAX);
      gain_update <= 1'b0;
      agc_locked  <= 1'b0;
      settle_q    <= '0;
      ir_q        <= '0;
      eval_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      gain_array  <= gain_d;
      gain_update <= upd_d;
      agc_locked  <= locked_d;
      settle_q    <= settle_d;
      ir_q        <= ir_d;
      eval_q      <= eval_d;
    end
  end

endmodule

// File: tb/tb_agc_gain_controller.sv
module tb_agc_gain_controller;

  logic       clk = 1'b0;
  logic       resetn;
  logic       agc_en;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic [6:0] thresh_high, thresh_low;
  logic [5:0] gain_array;
  logic       gain_update;
  logic       agc_locked;

  always #5 clk = ~clk;

  agc_gain_controller #(
    .DATA_W     (8),
    .WIN_LEN    (64),
    .SETTLE_CYC (16),
    .LOCK_CNT   (4),
    .GAIN_MAX   (38)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .agc_en      (agc_en),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .thresh_high (thresh_high),
    .thresh_low  (thresh_low),
    .gain_array  (gain_array),
    .gain_update (gain_update),
    .agc_locked  (agc_locked)
  );

  typedef struct {
    int gain;
    int gap;   // expected cycles since previous pulse, 0 = unchecked
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_cnt  = 0;
  int   last_pulse = 0;

  logic       ph = 1'b0;
  logic [7:0] pos_val, neg_val;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every gain_update pulse consumes one expected entry.
  always @(negedge clk) begin
    if (resetn === 1'b1 && gain_update === 1'b1) begin
      exp_t e;
      if (sb.size() == 0) begin
        check("unexpected_update", int'(gain_array), -1);
      end else begin
        e = sb.pop_front();
        check("update_gain", int'(gain_array), e.gain);
        if (e.gap != 0)
          check("update_gap", cyc_cnt - last_pulse, e.gap);
      end
      last_pulse = cyc_cnt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    ph = ~ph;
    adc_data = ph ? pos_val : neg_val;
  endtask

  task automatic set_amp(input logic [7:0] p, input logic [7:0] n);
    pos_val  = p;
    neg_val  = n;
    adc_data = ph ? pos_val : neg_val;
  endtask

  task automatic push(input int g, input int gap);
    exp_t e;
    e.gain = g;
    e.gap  = gap;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    agc_en = 1'b0;
    sb.delete();
    step();
    step();
    resetn = 1'b1;
  endtask

  initial begin
    int cyc;
    resetn      = 1'b0;
    agc_en      = 1'b0;
    adc_valid   = 1'b1;
    thresh_high = 7'd40;
    thresh_low  = 7'd20;
    set_amp(8'd127, -8'sd127);
    repeat (3) step();
    check("rst_gain", int'(gain_array), 38);
    check("rst_update", int'(gain_update), 0);
    check("rst_locked", int'(agc_locked), 0);
    resetn = 1'b1;

    // Disabled loop ignores full-scale input.
    repeat (200) step();
    check("dis_gain", int'(gain_array), 38);
    check("dis_locked", int'(agc_locked), 0);

    // Clipping: negative half at -128 must saturate to full scale (coarse step).
    set_amp(8'd100, 8'h80);
    agc_en = 1'b1;
    push(34, 0);
    for (int g = 30; g >= 2; g -= 4) push(g, 81);
    push(0, 81);
    cyc = 0;
    while (sb.size() != 0 && cyc < 1500) begin step(); cyc++; end
    check("clip_drain", sb.size(), 0);
    check("clip_gain0", int'(gain_array), 0);
    repeat (200) step();
    check("clip_hold0", int'(gain_array), 0);

    // In-range amplitude locks after 4 windows.
    do_reset();
    set_amp(8'd30, -8'sd30);
    agc_en = 1'b1;
    cyc = 0;
    while (agc_locked !== 1'b1 && cyc < 400) begin step(); cyc++; end
    check("lock_cycles", cyc, 261);
    check("lock_gain", int'(gain_array), 38);

    // Amplitude jump while locked: unlock plus fine decrement.
    set_amp(8'd50, -8'sd50);
    push(37, 0);
    cyc = 0;
    while (agc_locked !== 1'b0 && cyc < 200) begin step(); cyc++; end
    check("unlock_cycles", cyc, 65);
    check("unlock_gain", int'(gain_array), 37);
    check("unlock_pulse", int'(gain_update), 1);
    repeat (5) step();
    check("unlock_drain", sb.size(), 0);

    // Weak signal at max gain: clamp means no change and no settle.
    do_reset();
    set_amp(8'd4, -8'sd4);
    agc_en = 1'b1;
    repeat (300) step();
    check("clampmax_gain", int'(gain_array), 38);
    check("clampmax_locked", int'(agc_locked), 0);
    set_amp(8'd127, -8'sd127);
    push(34, 0);
    cyc = 0;
    while (gain_update !== 1'b1 && cyc < 200) begin step(); cyc++; end
    check("clampmax_nosettle", cyc, 26);
    step();
    check("clampmax_drain", sb.size(), 0);

    // Reset asserted mid-settle.
    do_reset();
    set_amp(8'd127, -8'sd127);
    agc_en = 1'b1;
    push(34, 0);
    push(30, 81);
    cyc = 0;
    while (sb.size() != 0 && cyc < 400) begin step(); cyc++; end
    check("settle_drain", sb.size(), 0);
    repeat (5) step();
    check("settle_gain30", int'(gain_array), 30);
    resetn = 1'b0;
    #1;
    check("async_gain", int'(gain_array), 38);
    check("async_update", int'(gain_update), 0);
    check("async_locked", int'(agc_locked), 0);
    step();
    step();
    resetn = 1'b1;
    push(34, 0);
    cyc = 0;
    while (gain_update !== 1'b1 && cyc < 200) begin step(); cyc++; end
    check("restart_cycles", cyc, 66);
    step();
    check("restart_drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
